// File: rtl/fulladder_exp1_pkg.sv
// Shared types and defaults for the full-adder cell family.
package fulladder_exp1_pkg;

    localparam int FA_REG_DEFAULT = 1;

    typedef struct packed {
        logic carry;
        logic sum;
    } fa_out_t;

    function automatic fa_out_t fa_eval(input logic a, input logic b, input logic cin);
        fa_out_t r;
        r.sum   = a ^ b ^ cin;
        r.carry = (a & b) | (a & cin) | (b & cin);
        return r;
    endfunction

endpackage

// File: rtl/fulladder_exp1_fa_cell.sv
// Combinational 1-bit full adder; zero latency, no backpressure.
module fa_cell
    import fulladder_exp1_pkg::*;
(
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    fa_out_t w_res;

    assign w_res = fa_eval(a, b, cin);
    assign sum   = w_res.sum;
    assign carry = w_res.carry;

endmodule

// File: rtl/fulladder_exp1.sv
// WIDTH independent full-adder lanes, optionally registered (1 cycle) or combinational (0 cycles).
// No flow control: with REG_OUT=1 the registers load every cycle.
module fulladder_exp1
    import fulladder_exp1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = FA_REG_DEFAULT
) (
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cin,
    input  logic             clk,
    input  logic             rst_n
);

    if (WIDTH < 1) begin : g_bad_width
        $error("fulladder_exp1: WIDTH must be >= 1");
    end
    if (REG_OUT != 0 && REG_OUT != 1) begin : g_bad_reg_out
        $error("fulladder_exp1: REG_OUT must be 0 or 1");
    end

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;

    // Lanes never share a carry; each is a standalone cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        fa_cell u_fa (
            .sum   (w_sum[i]),
            .carry (w_carry[i]),
            .a     (a[i]),
            .b     (b[i]),
            .cin   (cin[i])
        );
    end

    if (REG_OUT == 1) begin : g_reg
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_carry;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum   <= '0;
                r_carry <= '0;
            end else begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
        end

        assign sum   = r_sum;
        assign carry = r_carry;
    end else begin : g_comb
        assign sum   = w_sum;
        assign carry = w_carry;
    end

endmodule

// File: tb/tb_fulladder_exp1.sv
// Directed and back-to-back checks of registered, multi-lane and combinational adder instances.
module tb_fulladder_exp1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, cin4 = '0;
    logic       sum_r1, carry_r1, sum_c1, carry_c1;
    logic [3:0] sum_r4, carry_r4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fulladder_exp1 #(.WIDTH(1), .REG_OUT(1)) u_r1 (
        .sum(sum_r1), .carry(carry_r1), .a(a1), .b(b1), .cin(cin1),
        .clk(clk), .rst_n(rst_n));

    fulladder_exp1 #(.WIDTH(4), .REG_OUT(1)) u_r4 (
        .sum(sum_r4), .carry(carry_r4), .a(a4), .b(b4), .cin(cin4),
        .clk(clk), .rst_n(rst_n));

    fulladder_exp1 #(.WIDTH(1), .REG_OUT(0)) u_c1 (
        .sum(sum_c1), .carry(carry_c1), .a(a1), .b(b1), .cin(cin1),
        .clk(clk), .rst_n(rst_n));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: per-lane arithmetic addition, returns {carry[3:0], sum[3:0]}.
    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] s, cy;
        logic [1:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 2'({1'b0, a[i]}) + 2'(b[i]) + 2'(c[i]);
            s[i]  = t[0];
            cy[i] = t[1];
        end
        return {cy, s};
    endfunction

    initial begin
        logic [1:0] exp_tt [8];
        logic [1:0] prev;
        logic [7:0] exp4;
        logic [2:0] vin;
        exp_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state
        #2;
        check("rst_r1", {6'd0, carry_r1, sum_r1}, 8'h00);
        check("rst_r4", {carry_r4, sum_r4}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table: comb instance immediate, registered one edge later
        prev = 2'b00;
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            vin = 3'(v);
            {a1, b1, cin1} = vin;
            #1;
            check($sformatf("comb_tt%0d", v), {6'd0, carry_c1, sum_c1}, {6'd0, exp_tt[v]});
            check($sformatf("hold_tt%0d", v), {6'd0, carry_r1, sum_r1}, {6'd0, prev});
            @(posedge clk);
            #1;
            check($sformatf("reg_tt%0d", v), {6'd0, carry_r1, sum_r1}, {6'd0, exp_tt[v]});
            prev = exp_tt[v];
        end

        // Asynchronous reset with inputs held at 1
        @(negedge clk);
        {a1, b1, cin1} = 3'b111;
        @(posedge clk);
        #1;
        check("pre_rst", {6'd0, carry_r1, sum_r1}, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {6'd0, carry_r1, sum_r1}, 8'h00);
        check("comb_in_rst", {6'd0, carry_c1, sum_c1}, 8'h03);
        @(posedge clk);
        #1;
        check("rst_hold", {6'd0, carry_r1, sum_r1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", {6'd0, carry_r1, sum_r1}, 8'h03);

        // Lane independence
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0110; cin4 = 4'b0011;
        @(posedge clk);
        #1;
        check("lanes_a", {carry_r4, sum_r4}, {4'b0010, 4'b1111});
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0000; cin4 = 4'b1111;
        @(posedge clk);
        #1;
        check("lanes_b", {carry_r4, sum_r4}, {4'b1111, 4'b0000});

        // Half-adder use
        @(negedge clk);
        {a1, b1, cin1} = 3'b110;
        #1;
        check("ha11_comb", {6'd0, carry_c1, sum_c1}, 8'h02);
        @(posedge clk);
        #1;
        check("ha11_reg", {6'd0, carry_r1, sum_r1}, 8'h02);
        @(negedge clk);
        {a1, b1, cin1} = 3'b100;
        #1;
        check("ha10_comb", {6'd0, carry_c1, sum_c1}, 8'h01);
        @(posedge clk);
        #1;
        check("ha10_reg", {6'd0, carry_r1, sum_r1}, 8'h01);

        // Combinational cell ignores clk and rst_n
        @(negedge clk);
        {a1, b1, cin1} = 3'b101;
        #1;
        check("comb101", {6'd0, carry_c1, sum_c1}, 8'h02);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("comb101_rst", {6'd0, carry_c1, sum_c1}, 8'h02);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("comb101_clk", {6'd0, carry_c1, sum_c1}, 8'h02);

        // Back-to-back: new inputs every cycle, checked one cycle later
        @(negedge clk);
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 4'($urandom);
        exp4 = model4(a4, b4, cin4);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            check("b2b", {carry_r4, sum_r4}, exp4);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 4'($urandom);
            exp4 = model4(a4, b4, cin4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
